quadrature_encoder: RTL and testbench

Quadrature-signal generator that emulates a rotary or linear incremental encoder. It converts signed step commands into A/B/Z waveforms at a programmable edge rate and tracks the absolute position it has emitted. The block drives `quadrature_decoder` inputs in loopback benches and stands in for a physical encoder during motion-system bring-up. Position format (integer turns : fraction of circle) and Z placement match the decoder convention, so a decoder fed by this block reports the same position.

---
 rtl/quadrature_pkg.sv | 19 +
 rtl/quadrature_step_timer.sv | 45 ++++
 rtl/quadrature_encoder.sv | 150 +++++++++++++++
 tb/tb_quadrature_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_pkg.sv
// Shared types and helpers for the quadrature encoder: FSM states, the
// phase-to-A/B mapping and the default position half-width.
package quadrature_pkg;

    localparam int DEFAULT_POSITION_SIZE = 32;
    localparam int HALF_SIZE = DEFAULT_POSITION_SIZE / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SETTLE
    } state_t;

    // Gray-coded A/B from a 2-bit phase; returns {a, b}.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        return {phase[1] ^ phase[0], phase[1]};
    endfunction

endpackage

// File: rtl/quadrature_step_timer.sv
// Period counter: after start, ticks for one cycle every max(step_period,1)
// clocks until stopped. The period is re-sampled at every restart.
module quadrature_step_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] step_period,
    input  logic        start,
    input  logic        stop,
    output logic        tick
);

    logic        active;
    logic [31:0] count;
    logic [31:0] limit;
    logic [31:0] period_m1;

    assign period_m1 = (step_period == 32'd0) ? 32'd0 : step_period - 32'd1;
    assign tick      = active & (count == limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
        end else if (stop) begin
            active <= 1'b0;
        end
    end

    // count/limit are don't-care while inactive, so they carry no reset
    always_ff @(posedge clk) begin
        if (start) begin
            count <= 32'd0;
            limit <= period_m1;
        end else if (active) begin
            if (tick) begin
                count <= 32'd0;
                limit <= period_m1;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/quadrature_encoder.sv
// Incremental encoder emulator: turns signed step commands into A/B/Z edges
// at a programmable rate and tracks the emitted {turns, fraction} position.
module quadrature_encoder
    import quadrature_pkg::*;
#(
    parameter int POSITION_SIZE = DEFAULT_POSITION_SIZE
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       enable,
    input  logic [31:0]                step_period,
    input  logic [POSITION_SIZE/2:0]   steps_in_circle,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic signed [31:0]         cmd_steps,
    output logic                       busy,
    output logic                       done,
    output logic                       o_a,
    output logic                       o_b,
    output logic                       o_z,
    output logic                       direction,
    output logic [POSITION_SIZE-1:0]   absolute_position
);

    localparam int HW = POSITION_SIZE / 2;

    state_t        state, state_next;
    logic          accept, step_emit, finish, abort, tick;
    logic [31:0]   remaining;
    logic [31:0]   steps_mag;
    logic [1:0]    phase, phase_next;
    logic [HW-1:0] fraction, fraction_next;
    logic [HW-1:0] turns, turns_next;

    assign steps_mag = cmd_steps[31] ? unsigned'(-cmd_steps) : unsigned'(cmd_steps);

    quadrature_step_timer u_timer (
        .clk         (i_clk),
        .rst         (i_reset),
        .step_period (step_period),
        .start       (accept),
        .stop        (abort | finish),
        .tick        (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_emit  = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid & cmd_ready & enable) begin
                    accept     = 1'b1;
                    state_next = (cmd_steps == 32'sd0) ? SETTLE : RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (tick) begin
                    step_emit = 1'b1;
                    if (remaining == 32'd1) state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (tick) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fraction wraps at steps_in_circle; turns wrap naturally at 2^HW
    always_comb begin
        phase_next    = phase;
        fraction_next = fraction;
        turns_next    = turns;
        if (step_emit) begin
            if (direction) begin
                phase_next = phase + 2'd1;
                if (({1'b0, fraction} + (HW+1)'(1)) == steps_in_circle) begin
                    fraction_next = '0;
                    turns_next    = turns + HW'(1);
                end else begin
                    fraction_next = fraction + HW'(1);
                end
            end else begin
                phase_next = phase - 2'd1;
                if (fraction == '0) begin
                    fraction_next = steps_in_circle[HW-1:0] - HW'(1);
                    turns_next    = turns - HW'(1);
                end else begin
                    fraction_next = fraction - HW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cmd_ready         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            direction         <= 1'b0;
            phase             <= 2'd0;
            fraction          <= '0;
            turns             <= '0;
            o_a               <= 1'b0;
            o_b               <= 1'b0;
            o_z               <= 1'b1;
            absolute_position <= '0;
        end else begin
            cmd_ready         <= enable & (state == IDLE) & ~accept;
            busy              <= (state != IDLE);
            done              <= finish;
            if (accept) direction <= ~cmd_steps[31];
            phase             <= phase_next;
            fraction          <= fraction_next;
            turns             <= turns_next;
            {o_a, o_b}        <= phase_to_ab(phase_next);
            o_z               <= (fraction_next == '0);
            absolute_position <= {turns_next, fraction_next};
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            remaining <= steps_mag;
        end else if (step_emit) begin
            remaining <= remaining - 32'd1;
        end
    end

endmodule

// File: tb/tb_quadrature_encoder.sv
// Bench for quadrature_encoder: directed scenarios plus random +/- commands,
// each cycle compared against an arithmetic position/phase model.
module tb_quadrature_encoder;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               enable;
    logic [31:0]        step_period;
    logic [16:0]        steps_in_circle;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_steps;
    logic               busy, done, o_a, o_b, o_z, direction;
    logic [31:0]        absolute_position;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pos;
    int          m_phase;
    int          sic;
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quadrature_encoder #(.POSITION_SIZE(32)) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .enable            (enable),
        .step_period       (step_period),
        .steps_in_circle   (steps_in_circle),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_steps         (cmd_steps),
        .busy              (busy),
        .done              (done),
        .o_a               (o_a),
        .o_b               (o_b),
        .o_z               (o_z),
        .direction         (direction),
        .absolute_position (absolute_position)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Position after moving delta steps from start on a circle of s steps.
    function automatic logic [31:0] model_pos(input logic [31:0] start, input longint delta,
                                              input int s);
        longint total, t, f;
        logic [63:0] tv, fv;
        total = longint'(start[31:16]) * s + longint'(start[15:0]) + delta;
        t = total / s;
        f = total % s;
        if (f < 0) begin
            f = f + s;
            t = t - 1;
        end
        tv = t;
        fv = f;
        return {tv[15:0], fv[15:0]};
    endfunction

    function automatic int model_phase_at(input int ph, input longint delta);
        longint r;
        r = (longint'(ph) + delta) % 4;
        if (r < 0) r = r + 4;
        return int'(r);
    endfunction

    task automatic apply_reset(input int s);
        sic             = s;
        steps_in_circle = 17'(s);
        i_reset         = 1'b1;
        enable          = 1'b1;
        cmd_valid       = 1'b0;
        repeat (2) step();
        check("rst.ready", cmd_ready, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.ab", {o_a, o_b}, 2'b00);
        check("rst.z", o_z, 1);
        check("rst.dir", direction, 0);
        check("rst.pos", absolute_position, 0);
        i_reset = 1'b0;
        step();
        check("rst.ready_after", cmd_ready, 1);
        m_pos   = 32'd0;
        m_phase = 0;
    endtask

    task automatic issue(input int n, input int sp);
        int i;
        i = 0;
        while (!cmd_ready && i < 20) begin
            step();
            i++;
        end
        check("issue.ready", cmd_ready, 1);
        step_period = sp;
        cmd_steps   = n;
        cmd_valid   = 1'b1;
        step();
        cmd_valid   = 1'b0;
    endtask

    // Full command, checked every cycle from T+1 to T+(N+1)P+1.
    task automatic run_cmd(input string name, input int n, input int sp);
        int p, nabs, lim, s, sgn;
        logic [31:0] ep;
        p    = (sp < 1) ? 1 : sp;
        nabs = (n < 0) ? -n : n;
        sgn  = (n < 0) ? -1 : 1;
        lim  = (nabs + 1) * p;
        issue(n, sp);
        for (int j = 1; j <= lim + 1; j++) begin
            step();
            s  = (j / p < nabs) ? j / p : nabs;
            ep = model_pos(m_pos, longint'(sgn * s), sic);
            check({name, ".pos"}, absolute_position, ep);
            check({name, ".ab"}, {o_a, o_b}, ab_tab[model_phase_at(m_phase, longint'(sgn * s))]);
            check({name, ".z"}, o_z, ep[15:0] == 16'd0);
            check({name, ".done"}, done, j == lim);
            check({name, ".busy"}, busy, j <= lim);
            check({name, ".ready"}, cmd_ready, j > lim);
            if (n != 0) check({name, ".dir"}, direction, n > 0);
        end
        m_pos   = model_pos(m_pos, longint'(n), sic);
        m_phase = model_phase_at(m_phase, longint'(n));
    endtask

    initial begin
        logic [31:0] ep;
        i_reset         = 1'b1;
        enable          = 1'b1;
        step_period     = 32'd1;
        steps_in_circle = 17'd8;
        cmd_valid       = 1'b0;
        cmd_steps       = 32'sd0;

        apply_reset(8);
        run_cmd("fwd10", 10, 4);
        check("fwd10.final", m_pos, 32'h0001_0002);

        apply_reset(8);
        run_cmd("rev1", -1, 3);
        check("rev1.final", absolute_position, 32'hFFFF_0007);
        check("rev1.ab", {o_a, o_b}, 2'b01);
        check("rev1.z", o_z, 0);

        run_cmd("zero", 0, 5);

        // Abort: enable sampled low at the 21st edge after accept
        issue(100, 2);
        for (int j = 1; j <= 20; j++) begin
            step();
            ep = model_pos(m_pos, longint'(j / 2), sic);
            check("abort.pos", absolute_position, ep);
            check("abort.done", done, 0);
        end
        enable = 1'b0;
        step();
        ep = model_pos(m_pos, 64'sd10, sic);
        for (int j = 0; j < 5; j++) begin
            check("abort.hold_pos", absolute_position, ep);
            check("abort.hold_ab", {o_a, o_b}, ab_tab[model_phase_at(m_phase, 64'sd10)]);
            check("abort.hold_z", o_z, ep[15:0] == 16'd0);
            check("abort.no_done", done, 0);
            check("abort.ready", cmd_ready, 0);
            step();
            check("abort.busy", busy, 0);
        end
        m_pos   = ep;
        m_phase = model_phase_at(m_phase, 64'sd10);
        enable  = 1'b1;
        run_cmd("after_abort", -3, 1);

        apply_reset(65536);
        run_cmd("lin_rev", -1, 1);
        check("lin_rev.final", absolute_position, 32'hFFFF_FFFF);
        run_cmd("lin_fwd", 2, 0);
        check("lin_fwd.final", absolute_position, 32'h0000_0001);

        apply_reset(6);
        for (int k = 0; k < 14; k++) begin
            run_cmd("rand", int'($urandom_range(0, 24)) - 12, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
